mc_control_fsm: RTL and testbench

Second-generation control unit for the multi-cycle RV32I core. It is a 16-state FSM that drives the shared-memory datapath (PC, OldPC, IR, A/B, ALUOut, Data registers).
- Adds the full branch set and shift/compare ALU ops.
- Adds an optional memory wait-state handshake.
- Adds sticky illegal-instruction detection and a one-cycle retire strobe.

---
 rtl/mc_control_fsm.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle RV32I control unit. A 16-state FSM that sequences the
//   shared-memory datapath (PC, OldPC, IR, A/B, ALUOut, Data registers).
//   It supports the full branch set, shift/compare ALU ops, an optional
//   memory wait-state handshake, a sticky illegal-instruction flag and a
//   one-cycle retire strobe.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   opcode/funct3/funct7    instruction fields from IR
//   zero, lt, ltu           ALU compare flags for branches
//   mem_ready               memory access completes this cycle
//   mem_req, mem_write      memory request / store strobe
//   pc_write, ir_write      PC load, IR+OldPC load
//   reg_write               register file write enable
//   adr_src                 0 = PC, 1 = ALUOut as memory address
//   result_src              00 ALUOut, 01 Data, 10 ALU result
//   alu_src_a               00 PC, 01 OldPC, 10 A, 11 zero
//   alu_src_b               00 B, 01 imm, 10 constant 4
//   alu_control             0 ADD .. 9 SRA
//   imm_src                 000 I, 001 S, 010 B, 011 J, 100 U
//   illegal                 sticky illegal-instruction flag
//   instr_done              one-cycle retire pulse
//   state_dbg               current state encoding
module mc_control_fsm #(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            imm_src,
  output logic                  illegal,
  output logic                  instr_done,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_JAL       = 4'd9,
    S_JALR      = 4'd10,
    S_LINK      = 4'd11,
    S_BRANCH    = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_ILLEGAL   = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t  state, next_state;
  alu_op_t alu_dec, alu_sel;
  logic    ready;
  logic    taken;
  logic    illegal_q;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  assign illegal   = illegal_q;
  assign state_dbg = state;
  assign alu_control = ALU_CTRL_W'(alu_sel);

  // Immediate format depends only on the opcode.
  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_STORE:           imm_src = 3'b001;
      OP_BRANCH:          imm_src = 3'b010;
      OP_JAL:             imm_src = 3'b011;
      OP_LUI, OP_AUIPC:   imm_src = 3'b100;
      default:            imm_src = 3'b000;
    endcase
  end

  // SUB only exists for R-type; I-type funct3 000 is always ADD.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000: alu_dec = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_dec = ALU_SLL;
      3'b010: alu_dec = ALU_SLT;
      3'b011: alu_dec = ALU_SLTU;
      3'b100: alu_dec = ALU_XOR;
      3'b101: alu_dec = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: alu_dec = ALU_OR;
      3'b111: alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_sel    = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:              next_state = (funct7 == 7'h00 || funct7 == 7'h20)
                                          ? S_EXEC_R : S_ILLEGAL;
          OP_I:              next_state = S_EXEC_I;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_BRANCH:         next_state = (funct3 == 3'b010 || funct3 == 3'b011)
                                          ? S_ILLEGAL : S_BRANCH;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready)
          next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_sel    = alu_dec;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_sel    = alu_dec;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; ALU forms OldPC+4 for the link.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        next_state = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_sel    = ALU_SUB;
        pc_write   = taken;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        next_state = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        next_state = S_ALU_WB;
      end
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_FETCH;
    endcase

    // The state register already reads FETCH during reset; squash its
    // strobes and selects so nothing is requested until reset releases.
    if (reset) begin
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      result_src = '0;
      alu_src_a  = '0;
      alu_src_b  = '0;
      alu_sel    = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm with hand-computed expectations.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal, instr_done;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  mc_control_fsm #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .illegal(illegal), .instr_done(instr_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {pc_write, ir_write, reg_write, mem_write, mem_req, instr_done};
  endfunction

  initial begin
    reset = 1'b1;
    opcode = 7'h00; funct3 = 3'd0; funct7 = 7'h00;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_state", state_dbg, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_src_b", alu_src_b, 0);
    #5 reset = 1'b0;

    // add x3,x1,x2
    set_instr(7'h33, 3'd0, 7'h00);
    chk("add_fetch_state", state_dbg, 0);
    chk("add_fetch_strobes", strobes(), 6'b110010);
    chk("add_fetch_src_b", alu_src_b, 2);
    tick();
    chk("add_dec_state", state_dbg, 1);
    chk("add_dec_srcs", {alu_src_a, alu_src_b}, 4'b0101);
    chk("add_dec_imm", imm_src, 0);
    tick();
    chk("add_exec_state", state_dbg, 6);
    chk("add_exec_alu", alu_control, 0);
    chk("add_exec_regw", reg_write, 0);
    tick();
    chk("add_wb_state", state_dbg, 8);
    chk("add_wb_strobes", strobes(), 6'b001001);
    tick();
    chk("add_back_fetch", state_dbg, 0);

    // sub: R-type funct7[5]=1
    set_instr(7'h33, 3'd0, 7'h20);
    tick(); tick();
    chk("sub_alu", alu_control, 1);
    tick(); tick();

    // lw with two wait cycles in MEM_READ
    set_instr(7'h03, 3'd2, 7'h00);
    tick();
    chk("lw_dec_state", state_dbg, 1);
    tick();
    chk("lw_adr_state", state_dbg, 2);
    chk("lw_adr_srcs", {alu_src_a, alu_src_b}, 4'b1001);
    mem_ready = 1'b0;
    tick();
    chk("lw_rd1_state", state_dbg, 3);
    chk("lw_rd1_adr", adr_src, 1);
    chk("lw_rd1_strobes", strobes(), 6'b000010);
    tick();
    chk("lw_rd2_state", state_dbg, 3);
    chk("lw_rd2_adr", adr_src, 1);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_rd3_state", state_dbg, 3);
    chk("lw_rd3_strobes", strobes(), 6'b000010);
    tick();
    chk("lw_wb_state", state_dbg, 4);
    chk("lw_wb_strobes", strobes(), 6'b001001);
    chk("lw_wb_result", result_src, 1);
    tick();
    chk("lw_back_fetch", state_dbg, 0);

    // bne not taken (zero=1), then taken (zero=0)
    set_instr(7'h63, 3'd1, 7'h00);
    zero = 1'b1;
    chk("bne_imm", imm_src, 2);
    tick(); tick();
    chk("bne_nt_state", state_dbg, 12);
    chk("bne_nt_strobes", strobes(), 6'b000001);
    chk("bne_nt_alu", alu_control, 1);
    tick();
    chk("bne_nt_fetch", state_dbg, 0);
    zero = 1'b0;
    tick(); tick();
    chk("bne_t_strobes", strobes(), 6'b100001);
    tick();
    chk("bne_t_fetch", state_dbg, 0);

    // blt taken on lt, bgeu not taken on ltu
    set_instr(7'h63, 3'd4, 7'h00);
    lt = 1'b1;
    tick(); tick();
    chk("blt_taken", pc_write, 1);
    tick();
    set_instr(7'h63, 3'd7, 7'h00);
    ltu = 1'b1;
    tick(); tick();
    chk("bgeu_not_taken", pc_write, 0);
    tick();

    // srai, then addi with funct7[5]=1
    set_instr(7'h13, 3'd5, 7'h20);
    tick(); tick();
    chk("srai_state", state_dbg, 7);
    chk("srai_alu", alu_control, 9);
    chk("srai_src_b", alu_src_b, 1);
    tick(); tick();
    set_instr(7'h13, 3'd0, 7'h20);
    tick(); tick();
    chk("addi_f7_alu", alu_control, 0);
    tick(); tick();

    // jal
    set_instr(7'h6F, 3'd0, 7'h00);
    chk("jal_imm", imm_src, 3);
    tick(); tick();
    chk("jal_state", state_dbg, 9);
    chk("jal_ctrl", {pc_write, alu_src_a, alu_src_b, result_src}, 7'b1011000);
    tick();
    chk("jal_wb", state_dbg, 8);
    tick();

    // jalr
    set_instr(7'h67, 3'd0, 7'h00);
    tick(); tick();
    chk("jalr_ctrl", {state_dbg, pc_write, alu_src_a, alu_src_b, result_src}, {4'd10, 7'b1100110});
    tick();
    chk("link_ctrl", {state_dbg, strobes()}, {4'd11, 6'b001001});
    tick();

    // lui
    set_instr(7'h37, 3'd0, 7'h00);
    chk("lui_imm", imm_src, 4);
    tick(); tick();
    chk("lui_ctrl", {state_dbg, alu_src_a, alu_src_b}, {4'd13, 4'b1101});
    tick(); tick();

    // store completing immediately
    set_instr(7'h23, 3'd2, 7'h00);
    chk("sw_imm", imm_src, 1);
    tick(); tick(); tick();
    chk("sw_state", state_dbg, 5);
    chk("sw_strobes", strobes(), 6'b000111);
    tick();
    chk("sw_fetch", state_dbg, 0);

    // store stalled, reset asserted mid MEM_WRITE
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("sw2_wait_state", state_dbg, 5);
    chk("sw2_wait_strobes", strobes(), 6'b000010);
    reset = 1'b1;
    #1;
    chk("sw2_rst_state", state_dbg, 0);
    chk("sw2_rst_strobes", strobes(), 0);
    chk("sw2_rst_illegal", illegal, 0);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;

    // illegal opcode, sticky until reset
    set_instr(7'h7F, 3'd0, 7'h00);
    tick();
    chk("ill_dec_state", state_dbg, 1);
    chk("ill_dec_flag", illegal, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("ill_hold", {state_dbg, illegal, strobes()}, {4'd15, 1'b1, 6'b000000});
      tick();
    end
    reset = 1'b1;
    #1;
    chk("ill_rst_state", state_dbg, 0);
    chk("ill_rst_flag", illegal, 0);
    reset = 1'b0;

    // branch funct3 010 is illegal
    set_instr(7'h63, 3'd2, 7'h00);
    tick(); tick();
    chk("bfunct3_illegal", {state_dbg, illegal}, {4'd15, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
